// File: rtl/frame_color_classifier_if.sv
// frame_color_classifier_if: frame buffer scan stream in, 2-bit colour verdict out.
interface frame_color_classifier_if;
   logic [7:0] PIXEL_IN;
   logic [9:0] VGA_PIXEL_X;
   logic [9:0] VGA_PIXEL_Y;
   logic       VGA_VSYNC_NEG;
   logic [1:0] RESULT;
   logic       RESULT_VALID;
   modport master (output PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG, input RESULT, RESULT_VALID);
   modport slave (input PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG, output RESULT, RESULT_VALID);
endinterface

// File: rtl/frame_color_classifier.sv
// frame_color_classifier: counts red/blue RGB332 pixels in the image window and classifies each frame at vsync.
// Define FRAME_CLASSIFIER_HYSTERESIS_EN to require STABLE_FRAMES agreeing frames before RESULT changes.
module frame_color_classifier #(
   parameter int SCREEN_WIDTH  = 176,
   parameter int SCREEN_HEIGHT = 144,
   parameter int COLOR_THRESH  = 2000,
   parameter int STABLE_FRAMES = 2
) (
   input logic CLK,
   input logic RESET_N,
   frame_color_classifier_if.slave bus
);
   localparam logic [9:0]  WIN_W   = 10'(SCREEN_WIDTH);
   localparam logic [9:0]  WIN_H   = 10'(SCREEN_HEIGHT);
   localparam logic [14:0] THRESH  = 15'(COLOR_THRESH);
   localparam logic [14:0] CNT_MAX = '1;
   if (STABLE_FRAMES < 1 || STABLE_FRAMES > 7) begin : g_stable_range
      $error("STABLE_FRAMES must be in 1..7");
   end
   logic        in_win_q, in_win_d;
   logic        sync_q, sync_d;
   logic [14:0] red_cnt_q, red_cnt_d, blue_cnt_q, blue_cnt_d;
   logic [1:0]  result_q, result_d, decision;
   logic        valid_q, valid_d;
   logic        is_red, is_blue, frame_end;
   logic [2:0]  r, g;
   logic [1:0]  b;
   assign {r, g, b} = bus.PIXEL_IN;
   // sync_q holds "sync active"; resetting it to 1 means a sync already low at reset release is not an edge
   always_comb begin
      in_win_d   = (bus.VGA_PIXEL_X < WIN_W) && (bus.VGA_PIXEL_Y < WIN_H);
      sync_d     = ~bus.VGA_VSYNC_NEG;
      frame_end  = sync_d & ~sync_q;
      is_red     = in_win_q && r >= 3'd5 && g <= 3'd2 && b <= 2'd1;
      is_blue    = in_win_q && b == 2'd3 && r <= 3'd2 && g <= 3'd3;
      red_cnt_d  = frame_end ? {14'd0, is_red} : red_cnt_q + {14'd0, is_red && red_cnt_q != CNT_MAX};
      blue_cnt_d = frame_end ? {14'd0, is_blue} : blue_cnt_q + {14'd0, is_blue && blue_cnt_q != CNT_MAX};
      decision   = (red_cnt_q >= THRESH && red_cnt_q > blue_cnt_q) ? 2'b01 :
                   (blue_cnt_q >= THRESH && blue_cnt_q > red_cnt_q) ? 2'b10 : 2'b00;
      valid_d    = frame_end;
   end
`ifdef FRAME_CLASSIFIER_HYSTERESIS_EN
   localparam logic [2:0] STABLE_N = 3'(STABLE_FRAMES);
   logic [1:0] cand_q, cand_d;
   logic [2:0] stab_cnt_q, stab_cnt_d;
   always_comb begin
      cand_d     = frame_end ? decision : cand_q;
      stab_cnt_d = !frame_end ? stab_cnt_q :
                   decision != cand_q ? 3'd1 : stab_cnt_q + {2'd0, stab_cnt_q != 3'd7};
      result_d   = (frame_end && stab_cnt_d >= STABLE_N) ? cand_d : result_q;
   end
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         cand_q     <= 2'b00;
         stab_cnt_q <= 3'd0;
      end else begin
         cand_q     <= cand_d;
         stab_cnt_q <= stab_cnt_d;
      end
`else
   assign result_d = frame_end ? decision : result_q;
`endif
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         in_win_q   <= 1'b0;
         sync_q     <= 1'b1;
         red_cnt_q  <= '0;
         blue_cnt_q <= '0;
         result_q   <= 2'b00;
         valid_q    <= 1'b0;
      end else begin
         in_win_q   <= in_win_d;
         sync_q     <= sync_d;
         red_cnt_q  <= red_cnt_d;
         blue_cnt_q <= blue_cnt_d;
         result_q   <= result_d;
         valid_q    <= valid_d;
      end
   assign bus.RESULT       = result_q;
   assign bus.RESULT_VALID = valid_q;
endmodule

// File: tb/tb_frame_color_classifier.sv
// tb_frame_color_classifier: randomized frames scored against a frame-level colour-count model.
module tb_frame_color_classifier;
   localparam int STABLE = 2;
   logic CLK = 1'b0;
   logic RESET_N;
   logic rn = 1'b0;
   always #5 CLK = ~CLK;
   frame_color_classifier_if bus();
   frame_color_classifier #(.SCREEN_WIDTH(176), .SCREEN_HEIGHT(144), .COLOR_THRESH(2000), .STABLE_FRAMES(STABLE))
      dut (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));
   int checks = 0, errors = 0, valid_seen = 0;
   int exp_q[$];
   int m_red, m_blue, m_cand, m_stab, m_result;
   bit m_prev_win, m_prev_sync;
   logic [7:0] pend = 8'h00;
   logic [1:0] last_res = 2'b00;
   function automatic int pclass(input logic [7:0] p);
      int r = int'(p[7:5]), g = int'(p[4:2]), b = int'(p[1:0]);
      if (r >= 5 && g <= 2 && b <= 1) return 1;
      if (b == 3 && r <= 2 && g <= 3) return 2;
      return 0;
   endfunction
   function automatic logic [7:0] gen_pix(input int kind);
      logic [7:0] p;
      if (kind == 0) return {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 1))};
      if (kind == 1) return {3'($urandom_range(0, 2)), 3'($urandom_range(0, 3)), 2'd3};
      do p = 8'($urandom); while (pclass(p) != 0);
      return p;
   endfunction
   task automatic frame_verdict();
      int d = (m_red >= 2000 && m_red > m_blue) ? 1 : (m_blue >= 2000 && m_blue > m_red) ? 2 : 0;
`ifdef FRAME_CLASSIFIER_HYSTERESIS_EN
      if (d == m_cand) m_stab = (m_stab < 7) ? m_stab + 1 : 7;
      else begin m_cand = d; m_stab = 1; end
      if (m_stab >= STABLE) m_result = m_cand;
`else
      m_result = d;
`endif
      exp_q.push_back(m_result);
   endtask
   // one scan cycle: position (x,y) is presented now, its data one cycle later like the buffer RAM
   task automatic cyc(input logic [9:0] x, input logic [9:0] y, input logic [7:0] pix, input logic vs);
      int c;
      @(negedge CLK);
      RESET_N = rn;
      bus.VGA_PIXEL_X = x;
      bus.VGA_PIXEL_Y = y;
      bus.PIXEL_IN = pend;
      bus.VGA_VSYNC_NEG = vs;
      if (!rn) begin
         m_red = 0; m_blue = 0; m_cand = 0; m_stab = 0; m_result = 0;
         m_prev_win = 0; m_prev_sync = 1;
      end else begin
         if (!vs && !m_prev_sync) begin frame_verdict(); m_red = 0; m_blue = 0; end
         c = m_prev_win ? pclass(pend) : 0;
         if (c == 1 && m_red < 32767) m_red++;
         if (c == 2 && m_blue < 32767) m_blue++;
         m_prev_sync = !vs;
         m_prev_win = (x < 176) && (y < 144);
      end
      pend = pix;
   endtask
   task automatic burst(input int nr, input int nb, input int no, input int nout);
      int left[4];
      int tot, k, c;
      logic [9:0] x, y;
      left = '{nr, nb, no, nout};
      tot = nr + nb + no + nout;
      while (tot > 0) begin
         k = $urandom_range(0, tot - 1);
         c = 0;
         while (k >= left[c]) begin k -= left[c]; c++; end
         left[c]--;
         tot--;
         if (c < 3) begin
            x = 10'($urandom_range(0, 175)); y = 10'($urandom_range(0, 143));
         end else if ($urandom_range(0, 1) == 1) begin
            x = 10'($urandom_range(176, 639)); y = 10'($urandom_range(0, 479));
         end else begin
            x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(144, 479));
         end
         cyc(x, y, gen_pix(c == 3 ? 0 : c), 1'b1);
      end
   endtask
   task automatic vsync(input int low);
      repeat (low) cyc(10'd700, 10'd500, 8'($urandom), 1'b0);
      cyc(10'd700, 10'd500, 8'($urandom), 1'b1);
   endtask
   task automatic frame(input int nr, input int nb, input int no, input int nout);
      burst(nr, nb, no, nout);
      cyc(10'd700, 10'd0, 8'h00, 1'b1);
      vsync($urandom_range(2, 5));
   endtask
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (!RESET_N) begin
            checks++;
            if (bus.RESULT !== 2'b00 || bus.RESULT_VALID !== 1'b0) begin
               errors++;
               $display("FAIL reset_state: result=%b valid=%b, required 00/0", bus.RESULT, bus.RESULT_VALID);
            end
            last_res = 2'b00;
         end else if (bus.RESULT_VALID === 1'b1) begin
            int e;
            valid_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: result=%b with no frame end pending", bus.RESULT);
            end else begin
               e = exp_q.pop_front();
               if (bus.RESULT !== 2'(e)) begin
                  errors++;
                  $display("FAIL frame_result: got %b, required %b", bus.RESULT, 2'(e));
               end
            end
            last_res = bus.RESULT;
         end else begin
            checks++;
            if (bus.RESULT !== last_res) begin
               errors++;
               $display("FAIL result_hold: got %b, required held %b", bus.RESULT, last_res);
            end
         end
      end
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end
   initial begin
      int v0;
      rn = 1'b0;
      repeat (6) cyc(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 8'($urandom), 1'($urandom));
      repeat (3) cyc(10'($urandom_range(0, 175)), 10'($urandom_range(0, 143)), 8'($urandom), 1'b0);
      rn = 1'b1;
      v0 = valid_seen;
      repeat (20) cyc(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 8'($urandom), 1'b0);
      repeat (3) cyc(10'd700, 10'd500, 8'h00, 1'b1);
      checks++;
      if (valid_seen != v0) begin
         errors++;
         $display("FAIL release_in_sync: %0d valid pulses, required 0", valid_seen - v0);
      end
      exp_q.delete();
      m_red = 0; m_blue = 0;
      for (int y = 0; y < 144; y++)
         for (int x = 0; x < 176; x++)
            cyc(10'(x), 10'(y), 8'hE0, 1'b1);
      cyc(10'd700, 10'd0, 8'h00, 1'b1);
      vsync(4);
      frame(2500, 0, 0, 100);
      frame(0, 1999, 100, 50);
      frame(0, 2000, 100, 50);
      frame(3000, 3000, 0, 0);
      frame(0, 0, 0, 1500);
      burst(1999, 0, 50, 0);
      cyc(10'd20, 10'd20, 8'hE0, 1'b1);
      vsync(3);
      frame(1999, 0, 0, 0);
      for (int i = 0; i < 4; i++) frame(i % 2 == 0 ? 2500 : 0, i % 2 == 0 ? 0 : 2500, 0, 0);
      for (int i = 0; i < 5; i++)
         frame($urandom_range(600, 2200), $urandom_range(600, 2200), $urandom_range(0, 200), $urandom_range(0, 200));
      burst(1500, 1500, 0, 0);
      rn = 1'b0;
      repeat (3) cyc(10'($urandom_range(0, 175)), 10'($urandom_range(0, 143)), gen_pix(1), 1'b1);
      rn = 1'b1;
      frame(2200, 1000, 0, 0);
      frame(2200, 0, 0, 0);
      repeat (6) cyc(10'd700, 10'd500, 8'h00, 1'b1);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_results: %0d frame results never presented, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
